// File: rtl/pueo_cmdproc_assembler.sv
// pueo_cmdproc_assembler
// Packs the command-decoder byte stream into 32-bit words, first byte in [31:24].
// It buffers the words in a FIFO and drives them out on an AXI4-Stream master.
// The upstream stream cannot be stalled. When no FIFO slot is free the block drops
// the word, sets the sticky overflow flag and counts the damaged frame.
// Optional feature macro: CMDPROC_TIMEOUT_EN. When it is defined, an idle counter
// force-flushes a partial frame after TIMEOUT_CYCLES idle cycles.
module pueo_cmdproc_assembler #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        sysclk_i,
    input  logic        cmdproc_rst_i,
    input  logic [7:0]  s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    input  logic        s_cmd_tlast,
    output logic [31:0] m_cmd_tdata,
    output logic [3:0]  m_cmd_tkeep,
    output logic        m_cmd_tlast,
    output logic        m_cmd_tvalid,
    input  logic        m_cmd_tready,
    output logic        overflow_o,
    output logic [7:0]  drop_count_o,
    output logic        timeout_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    // Reject unusable configurations at elaboration
    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("pueo_cmdproc_assembler: unsupported FIFO_DEPTH/TIMEOUT_CYCLES");
    end

    logic [1:0]    state_q, state_d;
    logic [1:0]    count_q, count_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   merged_c;
    logic [3:0]    merged_keep_c;
    logic [3:0]    held_keep_c;
    logic          push_req_c;
    word_t         push_word_c;
    logic          push_ok_c;
    logic          room_c;
    logic          pop_c;
    logic          empty_c;
    logic          full_c;
    logic          timeout_d;
    logic          idle_hit_c;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] occupancy_c;
    word_t         mem [FIFO_DEPTH];
    word_t         rd_word_c;

    // FIFO status; a slot is free if not full or if the head leaves this cycle
    assign occupancy_c = PW'(wr_ptr_q - rd_ptr_q);
    assign empty_c     = (occupancy_c == '0);
    assign full_c      = (occupancy_c == PW'(FIFO_DEPTH));
    assign pop_c       = !empty_c && m_cmd_tready;
    assign room_c      = !full_c || pop_c;
    assign push_ok_c   = push_req_c && room_c;

    // Output stage is the FIFO head; it is stable until popped
    assign rd_word_c    = mem[rd_ptr_q[AW-1:0]];
    assign m_cmd_tvalid = !empty_c;
    assign m_cmd_tdata  = rd_word_c.data;
    assign m_cmd_tkeep  = rd_word_c.keep;
    assign m_cmd_tlast  = rd_word_c.last;

    // Merge the incoming byte into the lane after the held bytes
    always_comb begin
        merged_c      = 32'h0;
        merged_keep_c = 4'b0000;
        held_keep_c   = 4'b0000;
        case (count_q)
            2'd0: begin
                merged_c      = {s_cmd_tdata, 24'h0};
                merged_keep_c = 4'b1000;
                held_keep_c   = 4'b0000;
            end
            2'd1: begin
                merged_c      = {word_q[31:24], s_cmd_tdata, 16'h0};
                merged_keep_c = 4'b1100;
                held_keep_c   = 4'b1000;
            end
            2'd2: begin
                merged_c      = {word_q[31:16], s_cmd_tdata, 8'h0};
                merged_keep_c = 4'b1110;
                held_keep_c   = 4'b1100;
            end
            default: begin
                merged_c      = {word_q[31:8], s_cmd_tdata};
                merged_keep_c = 4'b1111;
                held_keep_c   = 4'b1110;
            end
        endcase
    end

`ifdef CMDPROC_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q;

    assign idle_hit_c = !s_cmd_tvalid && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    // Idle counter: runs mid-frame, clears on any byte or on a flush
    always_ff @(posedge sysclk_i) begin
        if (cmdproc_rst_i) begin
            idle_q <= '0;
        end else if (state_q == S_IDLE || s_cmd_tvalid || idle_hit_c) begin
            idle_q <= '0;
        end else begin
            idle_q <= IW'(idle_q + IW'(1));
        end
    end

    // Registered one-cycle flush pulse
    always_ff @(posedge sysclk_i) begin
        if (cmdproc_rst_i) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_d;
        end
    end
`else
    assign idle_hit_c = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    // Next-state logic: byte packing, word completion and drop handling
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_d      = word_q;
        push_req_c  = 1'b0;
        push_word_c = '0;
        timeout_d   = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (s_cmd_tvalid) begin
                    if (count_q == 2'd3 || s_cmd_tlast) begin
                        push_req_c       = 1'b1;
                        push_word_c.data = merged_c;
                        push_word_c.keep = merged_keep_c;
                        push_word_c.last = s_cmd_tlast;
                        count_d          = 2'd0;
                        word_d           = 32'h0;
                        state_d          = S_IDLE;
                    end else begin
                        word_d  = merged_c;
                        count_d = 2'(count_q + 2'd1);
                        state_d = S_ACCUM;
                    end
                end else if (state_q == S_ACCUM && idle_hit_c) begin
                    push_req_c       = 1'b1;
                    push_word_c.data = word_q;
                    push_word_c.keep = held_keep_c;
                    push_word_c.last = 1'b1;
                    count_d          = 2'd0;
                    word_d           = 32'h0;
                    state_d          = S_IDLE;
                    timeout_d        = 1'b1;
                end
            end
            S_DROP: begin
                if (s_cmd_tvalid && s_cmd_tlast) begin
                    state_d = S_IDLE;
                end else if (!s_cmd_tvalid && idle_hit_c) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 2'd0;
                word_d  = 32'h0;
            end
        endcase
        // A refused mid-frame word poisons the rest of the frame
        if (push_req_c && !room_c && !push_word_c.last) begin
            state_d = S_DROP;
        end
    end

    // State, partial word and error reporting registers
    always_ff @(posedge sysclk_i) begin
        if (cmdproc_rst_i) begin
            state_q      <= S_IDLE;
            count_q      <= 2'd0;
            word_q       <= 32'h0;
            overflow_o   <= 1'b0;
            drop_count_o <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            if (push_req_c && !room_c) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 8'hFF) begin
                    drop_count_o <= 8'(drop_count_o + 8'd1);
                end
            end
        end
    end

    // FIFO pointers
    always_ff @(posedge sysclk_i) begin
        if (cmdproc_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= PW'(wr_ptr_q + PW'(1));
            end
            if (pop_c) begin
                rd_ptr_q <= PW'(rd_ptr_q + PW'(1));
            end
        end
    end

    // FIFO storage
    always_ff @(posedge sysclk_i) begin
        if (!cmdproc_rst_i && push_ok_c) begin
            mem[wr_ptr_q[AW-1:0]] <= push_word_c;
        end
    end

endmodule

// File: tb/tb_pueo_cmdproc_assembler.sv
// Scoreboard bench for pueo_cmdproc_assembler. The stimulus pushes the expected
// words and a negedge monitor pops them on each output handshake.
module tb_pueo_cmdproc_assembler;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        timeout;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   to_pulses = 0;
    bit   hold_v = 1'b0;
    exp_t hold_w;

    always #5 clk = ~clk;

    pueo_cmdproc_assembler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .sysclk_i     (clk),
        .cmdproc_rst_i(rst),
        .s_cmd_tdata  (s_tdata),
        .s_cmd_tvalid (s_tvalid),
        .s_cmd_tlast  (s_tlast),
        .m_cmd_tdata  (m_tdata),
        .m_cmd_tkeep  (m_tkeep),
        .m_cmd_tlast  (m_tlast),
        .m_cmd_tvalid (m_tvalid),
        .m_cmd_tready (m_tready),
        .overflow_o   (overflow),
        .drop_count_o (drop_count),
        .timeout_o    (timeout)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: compares each accepted word and checks hold stability under backpressure
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = '{d: m_tdata, k: m_tkeep, l: m_tlast};
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (timeout === 1'b1) to_pulses++;
            if (hold_v) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_word", 64'(cur), 64'(hold_w));
            end
            hold_v = 1'b0;
            if (m_tvalid === 1'b1) begin
                if (m_tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%h expected=none", cur);
                    end else begin
                        e = sb.pop_front();
                        chk("word", 64'(cur), 64'(e));
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_w = cur;
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        sb.push_back('{d: d, k: k, l: l});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        s_tdata  = b;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && (sb.size() != 0 || m_tvalid); i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_pending", 64'(sb.size()), 64'd0);
        chk("drain_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        rst      = 1'b1;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // 5-byte frame: one full word then a 1-byte tail
        m_tready = 1'b1;
        expect_word(32'h11223344, 4'hF, 1'b0);
        expect_word(32'h55000000, 4'h8, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        chk("t1_no_early_valid", 64'(m_tvalid), 64'd0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("t1_latency", 64'(m_tvalid), 64'd1);
        send_byte(8'h55, 1'b1);
        wait_drain(20);

        // Single-byte frame, then 3-byte and 2-byte frames
        expect_word(32'hA5000000, 4'h8, 1'b1);
        send_byte(8'hA5, 1'b1);
        expect_word(32'h01020300, 4'hE, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        expect_word(32'h0A0B0000, 4'hC, 1'b1);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b1);
        wait_drain(20);

        // 17 frames into a stalled 16-deep FIFO
        m_tready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) w = {w[23:0], 8'(k * 4 + j + 1)};
            if (k < 16) expect_word(w, 4'hF, 1'b1);
            for (int j = 0; j < 4; j++) begin
                b = 8'(k * 4 + j + 1);
                send_byte(b, j == 3);
            end
        end
        @(negedge clk);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_count), 64'd1);
        chk("t3_tvalid", 64'(m_tvalid), 64'd1);
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_drain(100);

        // Full FIFO, 8-byte frame with one pop as the first word completes
        do_reset();
        m_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) w = {w[23:0], 8'(8'h80 + k * 4 + j)};
            expect_word(w, 4'hF, 1'b1);
            for (int j = 0; j < 4; j++) begin
                b = 8'(8'h80 + k * 4 + j);
                send_byte(b, j == 3);
            end
        end
        expect_word(32'hC1C2C3C4, 4'hF, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        m_tready = 1'b1;
        send_byte(8'hC4, 1'b0);
        m_tready = 1'b0;
        send_byte(8'hC5, 1'b0);
        send_byte(8'hC6, 1'b0);
        send_byte(8'hC7, 1'b0);
        send_byte(8'hC8, 1'b1);
        @(negedge clk);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_drop", 64'(drop_count), 64'd1);

        // Refused first word enters DROP; later bytes stay dropped even with space
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b0);
        send_byte(8'hD4, 1'b0);
        m_tready = 1'b1;
        send_byte(8'hD5, 1'b0);
        send_byte(8'hD6, 1'b1);
        @(negedge clk);
        chk("t4_drop_once", 64'(drop_count), 64'd2);
        wait_drain(100);
        expect_word(32'hE1000000, 4'h8, 1'b1);
        send_byte(8'hE1, 1'b1);
        wait_drain(20);
        chk("t4_drop_final", 64'(drop_count), 64'd2);

        // Reset mid-frame discards the partial word
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset();
        m_tready = 1'b1;
        expect_word(32'hCC000000, 4'h8, 1'b1);
        send_byte(8'hCC, 1'b1);
        wait_drain(20);

`ifdef CMDPROC_TIMEOUT_EN
        // Idle partial frame is flushed on the TO-th idle cycle
        to_pulses = 0;
        expect_word(32'h01020000, 4'hC, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("t6_before_flush", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_flush_valid", 64'(m_tvalid), 64'd1);
        chk("t6_timeout_pulse", 64'(timeout), 64'd1);
        @(posedge clk); #1;
        wait_drain(20);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_pulse_count", 64'(to_pulses), 64'd1);
`else
        // Without the timeout feature a partial frame waits for tlast
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_no_flush", 64'(m_tvalid), 64'd0);
        chk("t6_no_timeout", 64'(timeout), 64'd0);
        @(posedge clk); #1;
        expect_word(32'h01020300, 4'hE, 1'b1);
        send_byte(8'h03, 1'b1);
        wait_drain(20);
        chk("t6_pulse_count", 64'(to_pulses), 64'd0);
`endif

        chk("final_pending", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
